// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle MIPS32 control unit:
//   - state_t       : controller state encoding
//   - OP_*          : IR[31:26] opcode constants
//   - ALUOP_*       : ALUOp encodings
//   - SRCB_*        : ALUSrcB mux encodings
//   - PCSRC_*       : PCSource mux encodings
//   - decode_target : DECODE dispatch (S_FETCH means unsupported opcode)
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds BNE dispatch).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Successor of DECODE for a given opcode; S_FETCH flags an unsupported opcode.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:     nxt = S_EXECUTE;
      OP_LW, OP_SW: nxt = S_MEM_ADDR;
      OP_BEQ:       nxt = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
      OP_BNE:       nxt = S_BRANCH;
`endif
      OP_ADDI:      nxt = S_ADDI_EXEC;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts stall cycles of a memory-wait state and flags the timeout cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   active     : controller is in a memory-wait state
//   ready      : memory completes the access this cycle
//   expired    : limit reached with ready still low (LIMIT=0 never expires)
// The counter clears whenever the controller leaves the wait state, which
// happens exactly when it is inactive, ready is high, or the timeout fires.
// ---------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CW-1:0] r_count;
  logic          w_expired;

  assign w_expired = (LIMIT != 0) && active && !ready && (r_count == CW'(LIMIT));
  assign expired   = w_expired;

  // Stall counter: advances on each unready wait cycle, clears on state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!active || ready || w_expired || (LIMIT == 0)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore control unit for the multi-cycle MIPS32 datapath.
// Parameters: MEM_TIMEOUT (stall limit per memory state, 0 = no limit),
//             CNT_W (retired-instruction counter width).
// Inputs : clk, rst_n (async active-low), Opcode (IR[31:26]), mem_ready.
// Outputs: datapath strobes PCWrite..RegDst, PCSource, ALUSrcB, ALUOp,
//          BranchNe, illegal_op / mem_fault pulses, instr_count.
// Optional macro MULTICYCLE_CTRL_BNE_EN enables BNE (opcode 000101).
// Strobes decode combinationally from the state register so a reset drops
// them immediately; only IRWrite/PCWrite in FETCH look at mem_ready, and a
// memory timeout suppresses MemWrite in the faulting cycle.
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             BranchNe,
  output logic             illegal_op,
  output logic             mem_fault,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  logic [5:0]       r_opcode;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_wait_active;
  logic             w_expired;

  assign w_wait_active = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                         (r_state == S_MEM_WRITE);

  mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (w_wait_active),
    .ready   (mem_ready),
    .expired (w_expired)
  );

  // Sequencer: state, latched opcode and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_START;
      r_opcode      <= 6'b000000;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_START: r_state <= S_FETCH;
        S_FETCH: begin
          // A timeout in FETCH simply retries the fetch.
          if (mem_ready) r_state <= S_DECODE;
          else           r_state <= S_FETCH;
        end
        S_DECODE: begin
          r_opcode <= Opcode;
          r_state  <= decode_target(Opcode);
        end
        S_MEM_ADDR: begin
          if (r_opcode == OP_LW) r_state <= S_MEM_READ;
          else                   r_state <= S_MEM_WRITE;
        end
        S_MEM_READ: begin
          if (mem_ready)      r_state <= S_MEM_WB;
          else if (w_expired) r_state <= S_FETCH;
          else                r_state <= S_MEM_READ;
        end
        S_MEM_WRITE: begin
          if (mem_ready) begin
            r_state       <= S_FETCH;
            r_instr_count <= r_instr_count + CNT_W'(1);
          end else if (w_expired) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_MEM_WRITE;
          end
        end
        S_EXECUTE:   r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_R_WB, S_MEM_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
          r_state       <= S_FETCH;
          r_instr_count <= r_instr_count + CNT_W'(1);
        end
        default: r_state <= S_START;
      endcase
    end
  end

  // Per-state strobe decode.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUSrcB     = SRCB_REG;
    ALUOp       = ALUOP_ADD;
    BranchNe    = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = !w_expired;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
`ifdef MULTICYCLE_CTRL_BNE_EN
        BranchNe    = (r_opcode == OP_BNE);
`else
        BranchNe    = 1'b0;
`endif
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign illegal_op  = (r_state == S_DECODE) && (decode_target(Opcode) == S_FETCH);
  assign mem_fault   = w_expired;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench: each stimulus cycle pushes the hand-derived output vector
// and instr_count for that cycle; a monitor pops and compares at negedge.
// Output vector bit order (MSB..LSB): PCWrite PCWriteCond IorD MemRead
// MemWrite MemToReg IRWrite ALUSrcA RegWrite RegDst PCSource[1:0]
// ALUSrcB[1:0] ALUOp[1:0] BranchNe illegal_op mem_fault.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Opcode;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic        IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic        BranchNe, illegal_op, mem_fault;
  logic [31:0] instr_count;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .BranchNe(BranchNe), .illegal_op(illegal_op), .mem_fault(mem_fault),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [18:0] q_vec[$];
  logic [31:0] q_cnt[$];
  string       q_tag[$];

  logic [18:0] E_START, E_FETCH_W, E_FETCH_R, E_FETCH_FLT, E_DECODE, E_DECODE_ILL;
  logic [18:0] E_ADDR, E_MREAD, E_MWRITE, E_MWRITE_FLT, E_MWB, E_EXEC, E_RWB;
  logic [18:0] E_AWB, E_BR, E_BRNE, E_JUMP;
  logic [31:0] exp_cnt;

  function automatic logic [18:0] ov(
    input logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd,
    input logic [1:0] pcs, asb, aop, input logic bne, ill, flt);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, asb, aop, bne, ill, flt};
  endfunction

  // One controller cycle: drive inputs just after the edge, queue expectation.
  task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                      input logic [18:0] ev);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    Opcode    = op;
    q_vec.push_back(ev);
    q_cnt.push_back(exp_cnt);
    q_tag.push_back(tag);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  logic [18:0] m_ev, m_got;
  logic [31:0] m_ec;
  string       m_tag;
  always @(negedge clk) begin
    if (q_vec.size() != 0) begin
      m_ev  = q_vec.pop_front();
      m_ec  = q_cnt.pop_front();
      m_tag = q_tag.pop_front();
      m_got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, BranchNe,
               illegal_op, mem_fault};
      checks++;
      if (m_got !== m_ev) begin
        errors++;
        $display("FAIL %s outputs: got %b expected %b", m_tag, m_got, m_ev);
      end
      checks++;
      if (instr_count !== m_ec) begin
        errors++;
        $display("FAIL %s instr_count: got %0d expected %0d", m_tag, instr_count, m_ec);
      end
    end
  end

  initial begin
    int guard;
    E_START      = '0;
    E_FETCH_W    = ov(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0);
    E_FETCH_R    = ov(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0);
    E_FETCH_FLT  = ov(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b00,1'b0,1'b0,1'b1);
    E_DECODE     = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b0,1'b0);
    E_DECODE_ILL = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,2'b00,1'b0,1'b1,1'b0);
    E_ADDR       = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0);
    E_MREAD      = ov(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    E_MWRITE     = ov(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    E_MWRITE_FLT = ov(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1);
    E_MWB        = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    E_EXEC       = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0);
    E_RWB        = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    E_AWB        = ov(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0);
    E_BR         = ov(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b01,1'b0,1'b0,1'b0);
    E_BRNE       = ov(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b01,1'b1,1'b0,1'b0);
    E_JUMP       = ov(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0);
    exp_cnt   = 32'd0;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    Opcode    = 6'b000000;

    // Reset held, then released: START for one cycle.
    step("reset_held", 1'b0, 6'b000000, E_START);
    @(posedge clk); #1; rst_n = 1'b1;
    q_vec.push_back(E_START); q_cnt.push_back(exp_cnt); q_tag.push_back("start");

    // R-type, zero wait.
    step("r_fetch",  1'b1, 6'b000000, E_FETCH_R);
    step("r_decode", 1'b1, 6'b000000, E_DECODE);
    step("r_exec",   1'b1, 6'b111111, E_EXEC);
    step("r_wb",     1'b1, 6'b111111, E_RWB);
    exp_cnt = 32'd1;

    // lw with three unready MEM_READ cycles; opcode changes after DECODE.
    step("lw_fetch",  1'b1, 6'b100011, E_FETCH_R);
    step("lw_decode", 1'b1, 6'b100011, E_DECODE);
    step("lw_addr",   1'b1, 6'b101011, E_ADDR);
    for (int i = 0; i < 3; i++) step("lw_read_wait", 1'b0, 6'b101011, E_MREAD);
    step("lw_read",   1'b1, 6'b101011, E_MREAD);
    step("lw_wb",     1'b1, 6'b101011, E_MWB);
    exp_cnt = 32'd2;

    // sw with one unready MEM_WRITE cycle.
    step("sw_fetch",  1'b1, 6'b101011, E_FETCH_R);
    step("sw_decode", 1'b1, 6'b101011, E_DECODE);
    step("sw_addr",   1'b1, 6'b100011, E_ADDR);
    step("sw_wait",   1'b0, 6'b100011, E_MWRITE);
    step("sw_write",  1'b1, 6'b100011, E_MWRITE);
    exp_cnt = 32'd3;

    // addi.
    step("addi_fetch",  1'b1, 6'b001000, E_FETCH_R);
    step("addi_decode", 1'b1, 6'b001000, E_DECODE);
    step("addi_exec",   1'b1, 6'b001000, E_ADDR);
    step("addi_wb",     1'b1, 6'b001000, E_AWB);
    exp_cnt = 32'd4;

    // beq then j.
    step("beq_fetch",  1'b1, 6'b000100, E_FETCH_R);
    step("beq_decode", 1'b1, 6'b000100, E_DECODE);
    step("beq_branch", 1'b1, 6'b000100, E_BR);
    exp_cnt = 32'd5;
    step("j_fetch",  1'b1, 6'b000010, E_FETCH_R);
    step("j_decode", 1'b1, 6'b000010, E_DECODE);
    step("j_jump",   1'b1, 6'b000010, E_JUMP);
    exp_cnt = 32'd6;

    // Illegal opcode: pulse in DECODE, back to FETCH, count unchanged.
    step("ill_fetch",  1'b1, 6'b111111, E_FETCH_R);
    step("ill_decode", 1'b1, 6'b111111, E_DECODE_ILL);

    // FETCH timeout: 15 stall cycles, fault on the 16th.
    for (int i = 0; i < 15; i++) step("fetch_stall", 1'b0, 6'b000000, E_FETCH_W);
    step("fetch_fault", 1'b0, 6'b000000, E_FETCH_FLT);
    // Ready arriving exactly at the limit wins.
    for (int i = 0; i < 15; i++) step("fetch_stall2", 1'b0, 6'b000101, E_FETCH_W);
    step("fetch_ready_at_limit", 1'b1, 6'b000101, E_FETCH_R);
`ifdef MULTICYCLE_CTRL_BNE_EN
    step("bne_decode", 1'b1, 6'b000101, E_DECODE);
    step("bne_branch", 1'b1, 6'b000000, E_BRNE);
    exp_cnt = exp_cnt + 32'd1;
`else
    step("bne_decode_ill", 1'b1, 6'b000101, E_DECODE_ILL);
`endif

    // MEM_WRITE timeout: MemWrite suppressed in the fault cycle.
    step("swt_fetch",  1'b1, 6'b101011, E_FETCH_R);
    step("swt_decode", 1'b1, 6'b101011, E_DECODE);
    step("swt_addr",   1'b0, 6'b101011, E_ADDR);
    for (int i = 0; i < 15; i++) step("swt_stall", 1'b0, 6'b101011, E_MWRITE);
    step("swt_fault", 1'b0, 6'b101011, E_MWRITE_FLT);

    // Reset asserted mid MEM_WRITE: outputs and count drop before any edge.
    step("swr_fetch",  1'b1, 6'b101011, E_FETCH_R);
    step("swr_decode", 1'b1, 6'b101011, E_DECODE);
    step("swr_addr",   1'b0, 6'b101011, E_ADDR);
    step("swr_write",  1'b0, 6'b101011, E_MWRITE);
    @(posedge clk); #1; rst_n = 1'b0;
    exp_cnt = 32'd0;
    q_vec.push_back(E_START); q_cnt.push_back(exp_cnt); q_tag.push_back("async_reset");
    @(posedge clk); #1; rst_n = 1'b1;
    q_vec.push_back(E_START); q_cnt.push_back(exp_cnt); q_tag.push_back("restart");
    step("r2_fetch",  1'b1, 6'b000000, E_FETCH_R);
    step("r2_decode", 1'b1, 6'b000000, E_DECODE);
    step("r2_exec",   1'b1, 6'b000000, E_EXEC);
    step("r2_wb",     1'b1, 6'b000000, E_RWB);
    exp_cnt = 32'd1;
    step("r2_after",  1'b0, 6'b000000, E_FETCH_W);

    guard = 0;
    while (q_vec.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (q_vec.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q_vec.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control unit for the multi-cycle MIPS32 datapath, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. Datapath control strobes are driven per state. Memory accesses stall on a ready handshake, guarded by a configurable timeout, and a retired-instruction counter is maintained. It sits between the instruction register opcode field and the shared datapath muxes, register file, ALU control and unified memory.

## Interface
- MEM_TIMEOUT, 15: max stall cycles per memory state before fault; 0 disables timeout.
- CNT_W, 32: width of retired-instruction counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory completes current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath strobes.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- BranchNe  out  1  invert zero for PCWriteCond (0 when BNE disabled).
- illegal_op  out  1  one-cycle pulse on unsupported opcode.
- mem_fault  out  1  one-cycle pulse on memory timeout.
- instr_count  out  CNT_W  retired instructions.

## Operation
- States: START, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- Signals not listed for a state are 0.
  - START: all 0.
  - FETCH: MemRead, ALUSrcB=01; IRWrite and PCWrite only while mem_ready=1.
  - DECODE: ALUSrcB=11.
  - MEM_ADDR, ADDI_EXEC: ALUSrcA=1, ALUSrcB=10.
  - MEM_READ: MemRead, IorD.
  - MEM_WRITE: MemWrite, IorD.
  - MEM_WB: RegWrite, MemToReg.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - R_WB: RegWrite, RegDst.
  - ADDI_WB: RegWrite.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01.
  - JUMP: PCWrite, PCSource=10.
- Transitions:
  - START→FETCH.
  - FETCH→DECODE on mem_ready.
  - DECODE by Opcode:
    - 000000→EXECUTE.
    - 100011 or 101011→MEM_ADDR.
    - 000100→BRANCH.
    - 001000→ADDI_EXEC.
    - 000010→JUMP.
    - Any other opcode→FETCH with illegal_op pulse.
  - MEM_ADDR→MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ→MEM_WB on mem_ready.
  - MEM_WRITE→FETCH on mem_ready.
  - EXECUTE→R_WB; ADDI_EXEC→ADDI_WB.
  - R_WB, MEM_WB, ADDI_WB, BRANCH, JUMP→FETCH.
- Opcode is latched in DECODE; MEM_ADDR branches on the latched copy.
- Wait counter (ceil(log2(MEM_TIMEOUT+1)) bits) increments each cycle in FETCH/MEM_READ/MEM_WRITE with mem_ready=0.
  - Clears on any state change.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: pulse mem_fault, go to FETCH, no write strobes that cycle.
  - mem_ready=1 in the same cycle as the limit: ready wins, no fault.
- instr_count increments by 1 on the exiting cycle of MEM_WB, MEM_WRITE (ready), R_WB, ADDI_WB, BRANCH, JUMP.
  - Wraps modulo 2^CNT_W.
  - Never increments on illegal_op or mem_fault.

## Timing
- Reset values: state START, all strobes 0, pulses 0, instr_count 0, wait counter 0.
- rst_n assertion mid-instruction aborts it immediately; outputs drop to 0 asynchronously.
- First FETCH occurs one cycle after rst_n release.
- Outputs decode combinationally from the state register; mem_ready gates only IRWrite/PCWrite in FETCH.
- Zero-wait latencies in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each mem_ready=0 cycle adds one cycle.

## Configuration
- MULTICYCLE_CTRL_BNE_EN defined:
  - Opcode 000101 goes to BRANCH with BranchNe=1.
  - BranchNe is 0 in every other state.
- MULTICYCLE_CTRL_BNE_EN undefined:
  - BranchNe is tied 0.
  - 000101 is illegal (illegal_op pulse).

## Structure
- Package multicycle_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J);
  - ALUOp and ALUSrcB/PCSource encodings.
- Sub-module mem_wait_timer: counter with timeout compare.
  - Inputs: clk, rst_n, active, ready.
  - Output: expired.

## Test plan
- Reset, then R-type with mem_ready=1 → states START,FETCH,DECODE,EXECUTE,R_WB; RegWrite=RegDst=1 in cycle 4; instr_count=1.
- lw with mem_ready low 3 cycles in MEM_READ → 8-cycle instruction, MemToReg=1 in MEM_WB, no mem_fault.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=15 → mem_fault pulse after 15 stall cycles, state FETCH, instr_count unchanged.
- Opcode 111111 → illegal_op pulse leaving DECODE, next state FETCH, no RegWrite/MemWrite asserted.
- beq then j → BRANCH asserts PCWriteCond, ALUOp=01; JUMP asserts PCWrite, PCSource=10; instr_count +2.
- Opcode 000101 → BRANCH with BranchNe=1 when macro defined; illegal_op pulse otherwise. rst_n pulsed during MEM_WRITE → MemWrite drops immediately, restart via START.
